procyon_rs_scheduler: RTL and testbench

Control block for one reservation station (RS) of `OPTN_RS_DEPTH` entries. It allocates a free entry for each dispatcher reservation and steers the following cycle's dispatch data into that entry. Each cycle it selects the oldest ready entry for issue and tracks occupancy and backpressure. The block sits between the dispatcher, the array of RS entries, and the functional unit (FU) issue port; it drives the per-entry reserve, dispatch and issue enables and the age-update broadcast.

---
 rtl/procyon_rs_scheduler.sv | 142 ++++++++++++++
 tb/tb_procyon_rs_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/procyon_rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : procyon_rs_scheduler
//  Purpose  : Reservation-station control: entry allocation, dispatch steering,
//             oldest-ready issue selection, occupancy and backpressure.
//  Revision : 1.0
// ============================================================================
module procyon_rs_scheduler #(
  parameter int OPTN_RS_DEPTH = 16,
  parameter int RS_IDX_WIDTH  = $clog2(OPTN_RS_DEPTH),
  parameter int RS_CNT_WIDTH  = $clog2(OPTN_RS_DEPTH) + 1
) (
  input  logic                                       clk,
  input  logic                                       n_rst,

  input  logic                                       i_flush,

  input  logic [OPTN_RS_DEPTH-1:0]                   i_rs_entry_empty,
  input  logic [OPTN_RS_DEPTH-1:0]                   i_rs_entry_ready,
  input  logic [OPTN_RS_DEPTH-1:0][RS_IDX_WIDTH-1:0] i_rs_entry_age,

  input  logic                                       i_reserve_req,
  input  logic                                       i_dispatch_req,
  output logic                                       o_rs_stall,
  output logic                                       o_rs_full,
  output logic [RS_CNT_WIDTH-1:0]                    o_rs_occupancy,

  output logic [OPTN_RS_DEPTH-1:0]                   o_reserve_en,
  output logic [OPTN_RS_DEPTH-1:0]                   o_dispatch_en,
  output logic                                       o_dispatching,
  output logic [OPTN_RS_DEPTH-1:0]                   o_issue_en,
  output logic                                       o_issuing,
  output logic [RS_IDX_WIDTH-1:0]                    o_rs_issue_entry_age,

  input  logic                                       i_fu_stall,
  output logic                                       o_issue_valid,
  output logic [RS_IDX_WIDTH-1:0]                    o_issue_idx
);

  localparam logic [RS_CNT_WIDTH-1:0]  c_DEPTH_CNT = RS_CNT_WIDTH'(OPTN_RS_DEPTH);
  localparam logic [OPTN_RS_DEPTH-1:0] c_ONE_HOT0  = OPTN_RS_DEPTH'(1);

  logic                     r_pending;
  logic [RS_IDX_WIDTH-1:0]  r_pending_idx;
  logic [RS_CNT_WIDTH-1:0]  r_occupancy;
  logic                     r_issue_valid;
  logic [RS_IDX_WIDTH-1:0]  r_issue_idx;

  logic                     w_free_found;
  logic [RS_IDX_WIDTH-1:0]  w_free_idx;
  logic                     w_cand_found;
  logic [RS_IDX_WIDTH-1:0]  w_sel_idx;
  logic [RS_IDX_WIDTH-1:0]  w_sel_age;
  logic                     w_full;
  logic                     w_stall;
  logic                     w_reserve_accept;
  logic                     w_dispatch;
  logic                     w_issue;

  // Lowest-index empty entry is the allocation target.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = OPTN_RS_DEPTH - 1; i >= 0; i--) begin
      if (i_rs_entry_empty[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = RS_IDX_WIDTH'(i);
      end
    end
  end

  // Strict greater-than keeps the lowest index among equally old candidates.
  always_comb begin
    w_cand_found = 1'b0;
    w_sel_idx    = '0;
    w_sel_age    = '0;
    for (int i = 0; i < OPTN_RS_DEPTH; i++) begin
      if (i_rs_entry_ready[i] && (!w_cand_found || (i_rs_entry_age[i] > w_sel_age))) begin
        w_cand_found = 1'b1;
        w_sel_idx    = RS_IDX_WIDTH'(i);
        w_sel_age    = i_rs_entry_age[i];
      end
    end
  end

  // Full is judged on the registered count, so a same-cycle issue cannot free a slot.
  assign w_full           = (r_occupancy == c_DEPTH_CNT);
  assign w_stall          = w_full | ~w_free_found | (r_pending & ~i_dispatch_req);
  assign w_reserve_accept = i_reserve_req & ~w_stall & ~i_flush;
  assign w_dispatch       = r_pending & i_dispatch_req & ~i_flush;
  assign w_issue          = w_cand_found & ~i_fu_stall & ~i_flush;

  assign o_rs_stall           = w_stall;
  assign o_rs_full            = w_full;
  assign o_rs_occupancy       = r_occupancy;

  assign o_reserve_en         = w_reserve_accept ? (c_ONE_HOT0 << w_free_idx) : '0;
  assign o_dispatch_en        = w_dispatch ? (c_ONE_HOT0 << r_pending_idx) : '0;
  assign o_dispatching        = w_dispatch;
  assign o_issue_en           = w_issue ? (c_ONE_HOT0 << w_sel_idx) : '0;
  assign o_issuing            = w_issue;
  assign o_rs_issue_entry_age = w_issue ? w_sel_age : '0;

  assign o_issue_valid        = r_issue_valid;
  assign o_issue_idx          = r_issue_idx;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pending     <= 1'b0;
      r_pending_idx <= '0;
      r_occupancy   <= '0;
      r_issue_valid <= 1'b0;
      r_issue_idx   <= '0;
    end else begin
      r_issue_valid <= w_issue;
      if (w_issue) begin
        r_issue_idx <= w_sel_idx;
      end

      if (i_flush) begin
        r_pending   <= 1'b0;
        r_occupancy <= '0;
      end else begin
        // A new reservation in the dispatch cycle keeps the pending flag set.
        if (w_reserve_accept) begin
          r_pending     <= 1'b1;
          r_pending_idx <= w_free_idx;
        end else if (w_dispatch) begin
          r_pending <= 1'b0;
        end

        case ({w_reserve_accept, w_issue})
          2'b10:   r_occupancy <= r_occupancy + 1'b1;
          2'b01:   r_occupancy <= r_occupancy - 1'b1;
          default: r_occupancy <= r_occupancy;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_procyon_rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_procyon_rs_scheduler
//  Purpose  : Self-checking bench: directed scenarios then random traffic
//             against an entry-level model of the reservation station.
//  Revision : 1.0
// ============================================================================
module tb_procyon_rs_scheduler;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int CW = 5;

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic                 i_flush;
  logic [N-1:0]         i_rs_entry_empty;
  logic [N-1:0]         i_rs_entry_ready;
  logic [N-1:0][IW-1:0] i_rs_entry_age;
  logic                 i_reserve_req;
  logic                 i_dispatch_req;
  logic                 o_rs_stall;
  logic                 o_rs_full;
  logic [CW-1:0]        o_rs_occupancy;
  logic [N-1:0]         o_reserve_en;
  logic [N-1:0]         o_dispatch_en;
  logic                 o_dispatching;
  logic [N-1:0]         o_issue_en;
  logic                 o_issuing;
  logic [IW-1:0]        o_rs_issue_entry_age;
  logic                 i_fu_stall;
  logic                 o_issue_valid;
  logic [IW-1:0]        o_issue_idx;

  procyon_rs_scheduler #(.OPTN_RS_DEPTH(N)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .i_flush              (i_flush),
    .i_rs_entry_empty     (i_rs_entry_empty),
    .i_rs_entry_ready     (i_rs_entry_ready),
    .i_rs_entry_age       (i_rs_entry_age),
    .i_reserve_req        (i_reserve_req),
    .i_dispatch_req       (i_dispatch_req),
    .o_rs_stall           (o_rs_stall),
    .o_rs_full            (o_rs_full),
    .o_rs_occupancy       (o_rs_occupancy),
    .o_reserve_en         (o_reserve_en),
    .o_dispatch_en        (o_dispatch_en),
    .o_dispatching        (o_dispatching),
    .o_issue_en           (o_issue_en),
    .o_issuing            (o_issuing),
    .o_rs_issue_entry_age (o_rs_issue_entry_age),
    .i_fu_stall           (i_fu_stall),
    .o_issue_valid        (o_issue_valid),
    .o_issue_idx          (o_issue_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Entry model: 0 empty, 1 reserved (awaiting payload), 2 valid.
  int es [N];
  int m_occ, m_pend, m_pidx, m_iv, m_iidx;
  int x_acc, x_tgt, x_dsp, x_iss, x_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ages();
    for (int i = 0; i < N; i++) i_rs_entry_age[i] = IW'($urandom_range(0, N - 1));
  endtask

  task automatic drive(input bit res, input bit disp, input bit stall, input bit fl,
                       input logic [N-1:0] rdy);
    i_reserve_req    = res;
    i_dispatch_req   = disp;
    i_fu_stall       = stall;
    i_flush          = fl;
    i_rs_entry_ready = rdy;
    for (int i = 0; i < N; i++) i_rs_entry_empty[i] = (es[i] == 0);
  endtask

  task automatic comb_phase();
    bit full, any_empty, stall;
    int maxage;
    #2;
    full      = (m_occ == N);
    any_empty = 1'b0;
    x_tgt     = 0;
    for (int i = 0; i < N; i++) begin
      if (!any_empty && es[i] == 0) begin
        any_empty = 1'b1;
        x_tgt     = i;
      end
    end
    stall = full || !any_empty || (m_pend != 0 && !i_dispatch_req);
    x_acc = (i_reserve_req && !stall && !i_flush) ? 1 : 0;
    x_dsp = (m_pend != 0 && i_dispatch_req && !i_flush) ? 1 : 0;
    maxage = -1;
    for (int i = 0; i < N; i++)
      if (i_rs_entry_ready[i] && int'(i_rs_entry_age[i]) > maxage) maxage = int'(i_rs_entry_age[i]);
    x_sel = -1;
    for (int i = 0; i < N; i++)
      if (x_sel < 0 && i_rs_entry_ready[i] && int'(i_rs_entry_age[i]) == maxage) x_sel = i;
    x_iss = (x_sel >= 0 && !i_fu_stall && !i_flush) ? 1 : 0;

    chk("stall",       o_rs_stall,     stall);
    chk("full",        o_rs_full,      full);
    chk("occupancy",   o_rs_occupancy, m_occ);
    chk("reserve_en",  o_reserve_en,   x_acc ? (32'd1 << x_tgt) : 32'd0);
    chk("dispatch_en", o_dispatch_en,  x_dsp ? (32'd1 << m_pidx) : 32'd0);
    chk("dispatching", o_dispatching,  x_dsp);
    chk("issue_en",    o_issue_en,     x_iss ? (32'd1 << x_sel) : 32'd0);
    chk("issuing",     o_issuing,      x_iss);
    chk("issue_age",   o_rs_issue_entry_age, x_iss ? 32'(i_rs_entry_age[x_sel]) : 32'd0);
    if (o_issuing) chk("issue_occ_nonzero", (o_rs_occupancy != 0), 1);
  endtask

  task automatic clock_phase();
    int cnt;
    @(posedge clk);
    #1;
    if (i_flush) begin
      for (int i = 0; i < N; i++) es[i] = 0;
      m_occ  = 0;
      m_pend = 0;
    end else begin
      if (x_acc != 0) es[x_tgt] = 1;
      if (x_dsp != 0) es[m_pidx] = 2;
      if (x_iss != 0) es[x_sel] = 0;
      m_occ = m_occ + x_acc - x_iss;
      if (x_acc != 0) begin
        m_pend = 1;
        m_pidx = x_tgt;
      end else if (x_dsp != 0) begin
        m_pend = 0;
      end
    end
    m_iv = x_iss;
    if (x_iss != 0) m_iidx = x_sel;
    cnt = 0;
    for (int i = 0; i < N; i++) if (es[i] != 0) cnt++;
    chk("issue_valid", o_issue_valid,  m_iv);
    chk("issue_idx",   o_issue_idx,    m_iidx);
    chk("occ_entries", o_rs_occupancy, cnt);
  endtask

  task automatic cycle(input bit res, input bit disp, input bit stall, input bit fl,
                       input logic [N-1:0] rdy);
    drive(res, disp, stall, fl, rdy);
    comb_phase();
    clock_phase();
  endtask

  initial begin
    logic [N-1:0] rdy;
    for (int i = 0; i < N; i++) es[i] = 0;
    m_occ = 0; m_pend = 0; m_pidx = 0; m_iv = 0; m_iidx = 0;
    n_rst = 1'b0;
    rand_ages();
    drive(0, 0, 0, 0, '0);
    #13;
    chk("rst_occ",        o_rs_occupancy, 0);
    chk("rst_stall",      o_rs_stall,     0);
    chk("rst_full",       o_rs_full,      0);
    chk("rst_reserve_en", o_reserve_en,   0);
    chk("rst_dispatch",   o_dispatch_en,  0);
    chk("rst_issue_en",   o_issue_en,     0);
    chk("rst_issue_vld",  o_issue_valid,  0);
    chk("rst_issue_idx",  o_issue_idx,    0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Reserve then dispatch.
    drive(1, 0, 0, 0, '0);
    comb_phase();
    chk("rd_reserve_en", o_reserve_en, 16'h0001);
    clock_phase();
    drive(0, 1, 0, 0, '0);
    comb_phase();
    chk("rd_dispatch_en", o_dispatch_en, 16'h0001);
    clock_phase();
    chk("rd_occ", o_rs_occupancy, 1);

    // Fill with overlapped reserve/dispatch pairs.
    for (int k = 1; k < N; k++) cycle(1, k > 1, 0, 0, '0);
    cycle(0, 1, 0, 0, '0);
    chk("fill_full", o_rs_full, 1);
    drive(1, 0, 0, 0, '0);
    comb_phase();
    chk("fill_stall",   o_rs_stall,   1);
    chk("fill_res17",   o_reserve_en, 0);
    clock_phase();

    // Oldest ready, with a reserve attempt while full.
    rand_ages();
    i_rs_entry_age[3] = 4'd2;
    i_rs_entry_age[7] = 4'd5;
    i_rs_entry_age[9] = 4'd5;
    drive(1, 0, 0, 0, 16'h0288);
    comb_phase();
    chk("old_issue_en", o_issue_en, 16'h0080);
    chk("old_age",      o_rs_issue_entry_age, 5);
    chk("old_full_res", o_reserve_en, 0);
    clock_phase();
    chk("old_vld", o_issue_valid, 1);
    chk("old_idx", o_issue_idx, 7);

    // FU stall holds the issue back.
    drive(0, 0, 1, 0, 16'h0010);
    comb_phase();
    chk("fus_issuing", o_issuing, 0);
    clock_phase();
    drive(0, 0, 0, 0, 16'h0010);
    comb_phase();
    chk("fus_issue4", o_issue_en[4], 1);
    clock_phase();

    // Flush with a pending reservation, occupancy 5 and a ready entry.
    cycle(0, 0, 0, 1, '0);
    for (int k = 0; k < 5; k++) cycle(1, k > 0, 0, 0, '0);
    chk("fl_pre_occ", o_rs_occupancy, 5);
    rand_ages();
    drive(1, 1, 0, 1, 16'h0001);
    comb_phase();
    chk("fl_reserve_en",  o_reserve_en,  0);
    chk("fl_dispatch_en", o_dispatch_en, 0);
    chk("fl_dispatching", o_dispatching, 0);
    chk("fl_issue_en",    o_issue_en,    0);
    chk("fl_issuing",     o_issuing,     0);
    chk("fl_age",         o_rs_issue_entry_age, 0);
    clock_phase();
    chk("fl_occ", o_rs_occupancy, 0);
    drive(0, 1, 0, 0, '0);
    comb_phase();
    chk("fl_no_dispatch", o_dispatch_en, 0);
    clock_phase();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      rand_ages();
      rdy = '0;
      for (int i = 0; i < N; i++)
        if (es[i] == 2 && $urandom_range(0, 9) < 4) rdy[i] = 1'b1;
      cycle($urandom_range(0, 9) < 7,
            (m_pend != 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 1),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 49) == 0,
            rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
